ram_arbiter: RTL and testbench
==============================

RAM_ARBITER -- requirements
Module: ram_arbiter

Interface
REQ-001 Parameter ADDR_W, default 16: RAM address width in bits.
REQ-002 Parameter DATA_W, default 64: RAM data width in bits.
REQ-003 Parameter STARVE_MAX, default 3: consecutive data wins allowed while fetch waits (1..15).
REQ-004 Parameter TIMEOUT, default 255: maximum cycles spent waiting for ram_ready (1..255).
REQ-005 Port clk, input, 1: single clock; all state changes on its rising edge.
REQ-006 Port reset_n, input, 1: reset, asynchronous, active-low.
REQ-007 Port i_req, input, 1: instruction-fetch request.
REQ-008 Port i_addr, input, ADDR_W: fetch address.
REQ-009 Port i_gnt, output, 1: fetch access in progress.
REQ-010 Port i_done, output, 1: one-cycle pulse; fetch access complete.
REQ-011 Port i_rdata, output, DATA_W: fetched word, held until the next fetch completes.
REQ-012 Port d_req, input, 1: data-access request.
REQ-013 Port d_we, input, 1: 1 = write, 0 = read.
REQ-014 Port d_addr, input, ADDR_W: data address.
REQ-015 Port d_wdata, input, DATA_W: write data.
REQ-016 Port d_gnt, output, 1: data access in progress.
REQ-017 Port d_done, output, 1: one-cycle pulse; data access complete.
REQ-018 Port d_rdata, output, DATA_W: read word, held until the next data read completes.
REQ-019 Port ram_use, ram_read, ram_write, outputs, 1 each: RAM enable and strobes, registered.
REQ-020 Port ram_addr, output, ADDR_W, and ram_wdata, output, DATA_W: registered RAM address and write data.
REQ-021 Port ram_rdata, input, DATA_W, and ram_ready, input, 1: RAM read data and access-complete indication.
REQ-022 Port err, output, 1: one-cycle pulse; access aborted on timeout.

Function
REQ-023 FSM states: IDLE, BUSY_I, BUSY_D.
REQ-024 IDLE arbitration, one decision per cycle:
- d_req only: go to BUSY_D.
- i_req only: go to BUSY_I.
- both, starve counter < STARVE_MAX: data wins.
- both, starve counter = STARVE_MAX: fetch wins.
REQ-025 Starve counter: increments (saturating at STARVE_MAX) on each data win while i_req=1; clears on every fetch win.
REQ-026 On a grant, the winner's address, d_we and d_wdata are registered into ram_addr, ram_read/ram_write and ram_wdata.
- Fetch: ram_read=1, ram_write=0.
- Data: ram_write=d_we, ram_read=~d_we.
- ram_use=1.
REQ-027 In BUSY_x, ram_use, the strobes, ram_addr, ram_wdata and x_gnt stay constant.
REQ-028 Latency: request seen in IDLE at cycle N gives ram_use=1 and x_gnt=1 from cycle N+1.
REQ-029 Completion: ram_ready=1 in BUSY_x at cycle M causes the following at cycle M+1:
- x_done=1 for exactly one cycle.
- x_rdata = ram_rdata sampled at M; d_rdata updates on reads only.
- ram_use, strobes and x_gnt = 0.
- FSM returns to IDLE.
REQ-030 Minimum turnaround: one IDLE cycle always separates two accesses; back-to-back grants are not allowed.
REQ-031 Requester protocol: hold x_req and its address/data stable until x_done.
- Deasserting x_req mid-access does not abort; the access completes and x_done still pulses.
REQ-032 A requester still holding x_req in the IDLE cycle after its x_done is treated as a new request.
REQ-033 Timeout counter: clears on entry to BUSY_x and increments each BUSY cycle without ram_ready.
- Reaching TIMEOUT: err pulses one cycle, x_done pulses, x_rdata is left unchanged, all RAM outputs deassert, FSM returns to IDLE.
REQ-034 ram_ready in IDLE is ignored.
REQ-035 ram_ready in the same cycle the timeout count is reached counts as normal completion; err is not pulsed.

Reset
REQ-036 reset_n=0 asynchronously forces:
- FSM to IDLE.
- All 1-bit outputs to 0.
- ram_addr, ram_wdata, i_rdata, d_rdata to 0.
- Starve and timeout counters to 0.
REQ-037 Reset during BUSY_x aborts the access without any done or err pulse.
REQ-038 Arbitration resumes on the first rising edge after reset_n returns to 1.

Verification
REQ-039 Single fetch: i_req=1, i_addr=0x0040, ram_ready one cycle after grant with ram_rdata=0x30F4 -> i_gnt for 2 cycles, i_done one cycle later, i_rdata=0x30F4, d_* signals idle.
REQ-040 Data write: d_req=1, d_we=1, d_addr=0x0100, d_wdata=0xDEAD -> ram_write=1, ram_read=0, ram_addr=0x0100, ram_wdata=0xDEAD until ready; d_done pulses; d_rdata unchanged.
REQ-041 Contention, STARVE_MAX=3: i_req and d_req held continuously -> grant order D,D,D,I,D,D,D,I; each grant separated by one IDLE cycle.
REQ-042 Timeout, TIMEOUT=4: data read, ram_ready held 0 -> err and d_done pulse together after 4 BUSY cycles; RAM outputs 0; next request is granted normally.
REQ-043 Reset mid-access: reset_n low during BUSY_I -> all outputs 0 immediately; no i_done; after release, pending i_req is granted with latency 1.
REQ-044 Dropped request: d_req deasserted the cycle after d_gnt rises -> access still completes with d_done pulse; no second grant.

Source files
------------

// File: rtl/ram_arbiter_if.sv
// Bus bundle between the two RAM requesters (fetch and data), the arbiter and the RAM.
// The slave modport is the arbiter's view. The master modport is the view of the
// requesters and the RAM model.
interface ram_arbiter_if #(
  parameter int unsigned ADDR_W = 16,
  parameter int unsigned DATA_W = 64
);
  // Instruction-fetch requester
  logic              i_req;
  logic [ADDR_W-1:0] i_addr;
  logic              i_gnt;
  logic              i_done;
  logic [DATA_W-1:0] i_rdata;

  // Data requester
  logic              d_req;
  logic              d_we;
  logic [ADDR_W-1:0] d_addr;
  logic [DATA_W-1:0] d_wdata;
  logic              d_gnt;
  logic              d_done;
  logic [DATA_W-1:0] d_rdata;

  // RAM side
  logic              ram_use;
  logic              ram_read;
  logic              ram_write;
  logic [ADDR_W-1:0] ram_addr;
  logic [DATA_W-1:0] ram_wdata;
  logic [DATA_W-1:0] ram_rdata;
  logic              ram_ready;

  // Timeout abort pulse
  logic              err;

  modport slave (
    input  i_req, i_addr,
    output i_gnt, i_done, i_rdata,
    input  d_req, d_we, d_addr, d_wdata,
    output d_gnt, d_done, d_rdata,
    output ram_use, ram_read, ram_write, ram_addr, ram_wdata,
    input  ram_rdata, ram_ready,
    output err
  );

  modport master (
    output i_req, i_addr,
    input  i_gnt, i_done, i_rdata,
    output d_req, d_we, d_addr, d_wdata,
    input  d_gnt, d_done, d_rdata,
    input  ram_use, ram_read, ram_write, ram_addr, ram_wdata,
    output ram_rdata, ram_ready,
    input  err
  );
endinterface

// File: rtl/ram_arbiter.sv
// Two-port RAM arbiter. It shares one single-access RAM between the instruction fetch
// and data requesters.
// - Data has priority. Fetch is guaranteed a slot after STARVE_MAX consecutive data wins.
// - Every access is bounded by a TIMEOUT-cycle watchdog.
// - All outputs are registered.
module ram_arbiter #(
  parameter int unsigned ADDR_W     = 16,
  parameter int unsigned DATA_W     = 64,
  parameter int unsigned STARVE_MAX = 3,
  parameter int unsigned TIMEOUT    = 255
) (
  input  logic            clk,
  input  logic            reset_n,
  ram_arbiter_if.slave    bus
);

  localparam logic [3:0] StarveMax   = 4'(STARVE_MAX);
  // Abort at the end of the TIMEOUT-th busy cycle without ram_ready.
  localparam logic [7:0] TimeoutLast = 8'(TIMEOUT - 1);

  typedef enum logic [1:0] {
    StIdle,
    StBusyI,
    StBusyD
  } state_e;

  state_e     state_q;
  logic [3:0] starve_q;
  logic [7:0] tcnt_q;

  // Arbitration, access sequencing and all registered outputs
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q       <= StIdle;
      starve_q      <= '0;
      tcnt_q        <= '0;
      bus.i_gnt     <= 1'b0;
      bus.i_done    <= 1'b0;
      bus.i_rdata   <= '0;
      bus.d_gnt     <= 1'b0;
      bus.d_done    <= 1'b0;
      bus.d_rdata   <= '0;
      bus.ram_use   <= 1'b0;
      bus.ram_read  <= 1'b0;
      bus.ram_write <= 1'b0;
      bus.ram_addr  <= '0;
      bus.ram_wdata <= '0;
      bus.err       <= 1'b0;
    end else begin
      // Done and err are single-cycle pulses.
      bus.i_done <= 1'b0;
      bus.d_done <= 1'b0;
      bus.err    <= 1'b0;

      unique case (state_q)
        StIdle: begin
          // ram_ready is ignored here. Entering IDLE after each access gives the
          // mandatory one-cycle gap between grants.
          if (bus.d_req && (!bus.i_req || starve_q < StarveMax)) begin
            state_q       <= StBusyD;
            tcnt_q        <= '0;
            bus.d_gnt     <= 1'b1;
            bus.ram_use   <= 1'b1;
            bus.ram_write <= bus.d_we;
            bus.ram_read  <= ~bus.d_we;
            bus.ram_addr  <= bus.d_addr;
            bus.ram_wdata <= bus.d_wdata;
            // Count only wins that made fetch wait. The guard above keeps this below
            // StarveMax, so the count saturates there.
            if (bus.i_req) begin
              starve_q <= starve_q + 4'd1;
            end
          end else if (bus.i_req) begin
            state_q       <= StBusyI;
            tcnt_q        <= '0;
            starve_q      <= '0;
            bus.i_gnt     <= 1'b1;
            bus.ram_use   <= 1'b1;
            bus.ram_write <= 1'b0;
            bus.ram_read  <= 1'b1;
            bus.ram_addr  <= bus.i_addr;
            bus.ram_wdata <= '0;
          end
        end

        StBusyI, StBusyD: begin
          // ram_ready wins over a timeout reached in the same cycle.
          if (bus.ram_ready || tcnt_q == TimeoutLast) begin
            if (state_q == StBusyI) begin
              bus.i_done <= 1'b1;
              if (bus.ram_ready) begin
                bus.i_rdata <= bus.ram_rdata;
              end
            end else begin
              bus.d_done <= 1'b1;
              if (bus.ram_ready && bus.ram_read) begin
                bus.d_rdata <= bus.ram_rdata;
              end
            end
            bus.err       <= ~bus.ram_ready;
            state_q       <= StIdle;
            bus.i_gnt     <= 1'b0;
            bus.d_gnt     <= 1'b0;
            bus.ram_use   <= 1'b0;
            bus.ram_read  <= 1'b0;
            bus.ram_write <= 1'b0;
            bus.ram_addr  <= '0;
            bus.ram_wdata <= '0;
          end else begin
            tcnt_q <= tcnt_q + 8'd1;
          end
        end

        default: begin
          state_q <= StIdle;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_ram_arbiter.sv
// Directed bench for ram_arbiter. It uses STARVE_MAX=3 and TIMEOUT=4 so that the
// contention and timeout cases stay short.
module tb_ram_arbiter;

  localparam int unsigned AW = 16;
  localparam int unsigned DW = 64;

  logic clk = 1'b0;
  logic reset_n = 1'b0;
  int   checks = 0;
  int   errors = 0;
  logic [63:0] exp_drd;
  logic [63:0] exp_ird;

  always #5 clk = ~clk;

  ram_arbiter_if #(.ADDR_W(AW), .DATA_W(DW)) bus ();

  ram_arbiter #(
    .ADDR_W    (AW),
    .DATA_W    (DW),
    .STARVE_MAX(3),
    .TIMEOUT   (4)
  ) dut (
    .clk    (clk),
    .reset_n(reset_n),
    .bus    (bus.slave)
  );

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Advance one cycle; outputs are sampled and inputs driven 1 time unit after the edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    bus.i_req     = 1'b0;
    bus.i_addr    = '0;
    bus.d_req     = 1'b0;
    bus.d_we      = 1'b0;
    bus.d_addr    = '0;
    bus.d_wdata   = '0;
    bus.ram_rdata = '0;
    bus.ram_ready = 1'b0;
    exp_drd       = '0;
    exp_ird       = '0;

    // Reset state
    tick();
    tick();
    chk("rst_use", 64'(bus.ram_use), 0);
    chk("rst_gnt", 64'({bus.i_gnt, bus.d_gnt}), 0);
    chk("rst_done_err", 64'({bus.i_done, bus.d_done, bus.err}), 0);
    chk("rst_addr", 64'(bus.ram_addr), 0);
    chk("rst_drd", bus.d_rdata, 0);
    reset_n = 1'b1;
    tick();

    // Single fetch
    bus.i_req  = 1'b1;
    bus.i_addr = 16'h0040;
    tick();
    chk("f_gnt", 64'({bus.i_gnt, bus.d_gnt}), 64'b10);
    chk("f_strobes", 64'({bus.ram_use, bus.ram_read, bus.ram_write}), 64'b110);
    chk("f_addr", 64'(bus.ram_addr), 64'h0040);
    tick();
    chk("f_gnt2", 64'(bus.i_gnt), 1);
    bus.ram_ready = 1'b1;
    bus.ram_rdata = 64'h30F4;
    bus.i_req     = 1'b0;
    tick();
    exp_ird = 64'h30F4;
    chk("f_done", 64'({bus.i_done, bus.i_gnt, bus.ram_use}), 64'b100);
    chk("f_rdata", bus.i_rdata, exp_ird);
    chk("f_d_idle", 64'({bus.d_gnt, bus.d_done, bus.err}), 0);
    bus.ram_ready = 1'b0;
    tick();
    chk("f_done_pulse", 64'(bus.i_done), 0);

    // Data write: d_rdata must not change
    bus.d_req   = 1'b1;
    bus.d_we    = 1'b1;
    bus.d_addr  = 16'h0100;
    bus.d_wdata = 64'hDEAD;
    tick();
    chk("w_strobes", 64'({bus.d_gnt, bus.ram_use, bus.ram_read, bus.ram_write}), 64'b1101);
    chk("w_addr", 64'(bus.ram_addr), 64'h0100);
    chk("w_wdata", bus.ram_wdata, 64'hDEAD);
    bus.ram_ready = 1'b1;
    bus.ram_rdata = 64'h1234;
    bus.d_req     = 1'b0;
    tick();
    chk("w_done", 64'({bus.d_done, bus.d_gnt, bus.ram_write}), 64'b100);
    chk("w_drd", bus.d_rdata, exp_drd);
    bus.ram_ready = 1'b0;
    tick();

    // Data read updates d_rdata only
    bus.d_req  = 1'b1;
    bus.d_we   = 1'b0;
    bus.d_addr = 16'h0200;
    tick();
    chk("r_strobes", 64'({bus.ram_read, bus.ram_write}), 64'b10);
    bus.ram_ready = 1'b1;
    bus.ram_rdata = 64'hABCD;
    bus.d_req     = 1'b0;
    tick();
    exp_drd = 64'hABCD;
    chk("r_drd", bus.d_rdata, exp_drd);
    chk("r_ird", bus.i_rdata, exp_ird);
    bus.ram_ready = 1'b0;
    tick();

    // Contention: grant order D,D,D,I,D,D,D,I with an idle cycle between grants
    bus.i_req  = 1'b1;
    bus.i_addr = 16'h0010;
    bus.d_req  = 1'b1;
    bus.d_we   = 1'b0;
    bus.d_addr = 16'h0020;
    for (int g = 0; g < 8; g++) begin
      logic is_i;
      is_i = (g == 3 || g == 7);
      tick();
      chk($sformatf("c%0d_gnt", g), 64'({bus.i_gnt, bus.d_gnt}), is_i ? 64'b10 : 64'b01);
      chk($sformatf("c%0d_addr", g), 64'(bus.ram_addr), is_i ? 64'h0010 : 64'h0020);
      bus.ram_ready = 1'b1;
      bus.ram_rdata = 64'h5000 + 64'(g);
      if (g == 7) begin
        bus.i_req = 1'b0;
        bus.d_req = 1'b0;
      end
      tick();
      if (is_i) exp_ird = 64'h5000 + 64'(g);
      else exp_drd = 64'h5000 + 64'(g);
      chk($sformatf("c%0d_idle", g), 64'({bus.i_gnt, bus.d_gnt, bus.ram_use}), 0);
      chk($sformatf("c%0d_done", g), 64'({bus.i_done, bus.d_done}), is_i ? 64'b10 : 64'b01);
      bus.ram_ready = 1'b0;
    end
    chk("c_ird", bus.i_rdata, exp_ird);
    chk("c_drd", bus.d_rdata, exp_drd);
    tick();

    // Timeout on a data read after 4 busy cycles
    bus.d_req     = 1'b1;
    bus.d_we      = 1'b0;
    bus.d_addr    = 16'h0300;
    bus.ram_rdata = 64'hBAD;
    tick();
    chk("t_gnt1", 64'(bus.d_gnt), 1);
    bus.d_req = 1'b0;
    tick();
    tick();
    tick();
    chk("t_gnt4", 64'({bus.d_gnt, bus.err, bus.d_done}), 64'b100);
    tick();
    chk("t_err", 64'({bus.err, bus.d_done}), 64'b11);
    chk("t_ram_off", 64'({bus.ram_use, bus.ram_read, bus.ram_write, bus.d_gnt}), 0);
    chk("t_addr", 64'(bus.ram_addr), 0);
    chk("t_drd", bus.d_rdata, exp_drd);
    tick();
    chk("t_err_pulse", 64'({bus.err, bus.d_done}), 0);

    // Normal grant after the timeout
    bus.i_req  = 1'b1;
    bus.i_addr = 16'h0044;
    tick();
    chk("ta_gnt", 64'(bus.i_gnt), 1);
    bus.ram_ready = 1'b1;
    bus.ram_rdata = 64'h77;
    bus.i_req     = 1'b0;
    tick();
    exp_ird = 64'h77;
    chk("ta_done", 64'({bus.i_done, bus.err}), 64'b10);
    chk("ta_ird", bus.i_rdata, exp_ird);
    bus.ram_ready = 1'b0;
    tick();

    // ram_ready in the same cycle as the timeout completes normally
    bus.d_req  = 1'b1;
    bus.d_addr = 16'h0400;
    tick();
    bus.d_req = 1'b0;
    tick();
    tick();
    tick();
    bus.ram_ready = 1'b1;
    bus.ram_rdata = 64'h99;
    tick();
    exp_drd = 64'h99;
    chk("te_done", 64'({bus.d_done, bus.err}), 64'b10);
    chk("te_drd", bus.d_rdata, exp_drd);
    tick();

    // ram_ready while idle is ignored
    chk("ri_idle", 64'({bus.i_done, bus.d_done, bus.err, bus.ram_use}), 0);
    bus.ram_ready = 1'b0;

    // Reset during a fetch
    bus.i_req  = 1'b1;
    bus.i_addr = 16'h0080;
    tick();
    chk("rm_gnt", 64'(bus.i_gnt), 1);
    #2;
    reset_n = 1'b0;
    #1;
    chk("rm_out", 64'({bus.i_gnt, bus.ram_use, bus.ram_read, bus.i_done}), 0);
    chk("rm_addr", 64'(bus.ram_addr), 0);
    chk("rm_rdata", bus.i_rdata | bus.d_rdata, 0);
    tick();
    reset_n = 1'b1;
    exp_ird = '0;
    exp_drd = '0;
    chk("rm_nodone", 64'({bus.i_done, bus.err, bus.i_gnt}), 0);
    tick();
    chk("rm_regnt", 64'({bus.i_gnt, bus.ram_use}), 64'b11);
    chk("rm_addr2", 64'(bus.ram_addr), 64'h0080);
    bus.ram_ready = 1'b1;
    bus.ram_rdata = 64'h55;
    bus.i_req     = 1'b0;
    tick();
    chk("rm_done", 64'(bus.i_done), 1);
    bus.ram_ready = 1'b0;
    tick();

    // Dropped request still completes, with no second grant
    bus.d_req   = 1'b1;
    bus.d_we    = 1'b1;
    bus.d_addr  = 16'h0500;
    bus.d_wdata = 64'h1;
    tick();
    chk("dr_gnt", 64'(bus.d_gnt), 1);
    bus.d_req = 1'b0;
    tick();
    chk("dr_gnt2", 64'(bus.d_gnt), 1);
    bus.ram_ready = 1'b1;
    tick();
    chk("dr_done", 64'({bus.d_done, bus.d_gnt}), 64'b10);
    chk("dr_drd", bus.d_rdata, exp_drd);
    bus.ram_ready = 1'b0;
    tick();
    chk("dr_nogrant1", 64'({bus.d_gnt, bus.ram_use, bus.d_done}), 0);
    tick();
    chk("dr_nogrant2", 64'({bus.d_gnt, bus.ram_use}), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
